// File: rtl/dma_reg_file.sv
// Four-channel DMA register file with CPU strobe-edge commits; optional temp register under DMA_TEMP_REG_EN.
// Writes/read side effects commit one cycle after strobe release; read data is combinational; no backpressure.
module dma_reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        ior_n,
    input  logic        iow_n,
    input  logic        hlda,
    input  logic [3:0]  addr,
    input  logic [7:0]  db_in,
    output logic [7:0]  db_out,
    output logic        db_oe,
    input  logic        upd_en,
    input  logic [1:0]  upd_ch,
    input  logic [15:0] upd_addr,
    input  logic [15:0] upd_count,
    input  logic [3:0]  tc_set,
    input  logic [3:0]  dreq_stat,
    input  logic        temp_load,
    input  logic [7:0]  temp_in,
    output logic [7:0]  cmd_reg,
    output logic [31:0] mode_regs,
    output logic [3:0]  mask_bits,
    output logic [3:0]  req_bits,
    output logic [63:0] base_addr,
    output logic [63:0] curr_addr,
    output logic [63:0] base_cnt,
    output logic [63:0] curr_cnt
);

    logic        iow_d, ior_d;
    logic        acc_ok, wr, rd, ch_acc, mclr;
    logic        ptr, ptr_d;
    logic [3:0]  tc_flags, tc_d;
    logic [3:0]  reload_pend, reload_d;
    logic [3:0]  req_d, mask_d;
    logic [7:0]  cmd_d;
    logic [7:0]  mode_q [4];
    logic [7:0]  mode_d [4];
    logic [15:0] ba_q [4];
    logic [15:0] ca_q [4];
    logic [15:0] bc_q [4];
    logic [15:0] cc_q [4];
    logic [15:0] ba_d [4];
    logic [15:0] ca_d [4];
    logic [15:0] bc_d [4];
    logic [15:0] cc_d [4];
    logic [15:0] rsel;
    logic [7:0]  temp_val;

    // Strobe history survives master clear so the clearing write itself completes cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iow_d <= 1'b1;
            ior_d <= 1'b1;
        end else begin
            iow_d <= iow_n;
            ior_d <= ior_n;
        end
    end

    assign acc_ok = ~cs_n & ~hlda;
    assign wr     = acc_ok & ~iow_d & iow_n;
    assign rd     = acc_ok & ~ior_d & ior_n;
    assign ch_acc = ~addr[3];
    assign mclr   = wr & (addr == 4'hD);

    always_comb begin
        cmd_d    = cmd_reg;
        mode_d   = mode_q;
        req_d    = req_bits;
        mask_d   = mask_bits;
        reload_d = 4'h0;
        tc_d     = ((rd && addr == 4'h8) ? 4'h0 : tc_flags) | tc_set;
        ptr_d    = ptr;
        if (wr && addr == 4'hC)
            ptr_d = 1'b0;
        else if ((wr || rd) && ch_acc)
            ptr_d = ~ptr;

        // Precedence for current registers: auto-init reload < timing write-back < CPU byte write.
        for (int n = 0; n < 4; n++) begin
            ba_d[n] = ba_q[n];
            bc_d[n] = bc_q[n];
            ca_d[n] = reload_pend[n] ? ba_q[n] : ca_q[n];
            cc_d[n] = reload_pend[n] ? bc_q[n] : cc_q[n];
            if (upd_en && upd_ch == 2'(n)) begin
                ca_d[n] = upd_addr;
                cc_d[n] = upd_count;
            end
            if (wr && ch_acc && addr[2:1] == 2'(n)) begin
                if (!addr[0]) begin
                    if (ptr) begin
                        ba_d[n][15:8] = db_in;
                        ca_d[n][15:8] = db_in;
                    end else begin
                        ba_d[n][7:0] = db_in;
                        ca_d[n][7:0] = db_in;
                    end
                end else begin
                    if (ptr) begin
                        bc_d[n][15:8] = db_in;
                        cc_d[n][15:8] = db_in;
                    end else begin
                        bc_d[n][7:0] = db_in;
                        cc_d[n][7:0] = db_in;
                    end
                end
            end
        end

        if (wr && addr[3]) begin
            case (addr[2:0])
                3'b000:  cmd_d = db_in;
                3'b001:  req_d[db_in[1:0]] = db_in[2];
                3'b010:  mask_d[db_in[1:0]] = db_in[2];
                3'b011:  mode_d[db_in[1:0]] = db_in;
                3'b110:  mask_d = 4'h0;
                3'b111:  mask_d = db_in[3:0];
                default: ;
            endcase
        end

        for (int n = 0; n < 4; n++) begin
            if (tc_set[n]) begin
                req_d[n] = 1'b0;
                if (mode_q[n][4])
                    reload_d[n] = 1'b1;
                else
                    mask_d[n] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || mclr) begin
            cmd_reg     <= 8'h00;
            req_bits    <= 4'h0;
            mask_bits   <= 4'hF;
            tc_flags    <= 4'h0;
            reload_pend <= 4'h0;
            ptr         <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                mode_q[n] <= 8'h00;
                ba_q[n]   <= 16'h0000;
                ca_q[n]   <= 16'h0000;
                bc_q[n]   <= 16'h0000;
                cc_q[n]   <= 16'h0000;
            end
        end else begin
            cmd_reg     <= cmd_d;
            req_bits    <= req_d;
            mask_bits   <= mask_d;
            tc_flags    <= tc_d;
            reload_pend <= reload_d;
            ptr         <= ptr_d;
            for (int n = 0; n < 4; n++) begin
                mode_q[n] <= mode_d[n];
                ba_q[n]   <= ba_d[n];
                ca_q[n]   <= ca_d[n];
                bc_q[n]   <= bc_d[n];
                cc_q[n]   <= cc_d[n];
            end
        end
    end

`ifdef DMA_TEMP_REG_EN
    logic [7:0] temp_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset || mclr)
            temp_q <= 8'h00;
        else if (temp_load)
            temp_q <= temp_in;
    end
    assign temp_val = temp_q;
`else
    logic unused_temp;
    assign unused_temp = ^{temp_load, temp_in};
    assign temp_val    = 8'h00;
`endif

    assign db_oe = ~reset & ~cs_n & ~ior_n & ~hlda;
    assign rsel  = addr[0] ? cc_q[addr[2:1]] : ca_q[addr[2:1]];

    always_comb begin
        db_out = 8'h00;
        if (db_oe) begin
            if (ch_acc)
                db_out = ptr ? rsel[15:8] : rsel[7:0];
            else if (addr == 4'h8)
                db_out = {dreq_stat, tc_flags};
            else if (addr == 4'hD)
                db_out = temp_val;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign mode_regs[8*g +: 8]  = mode_q[g];
        assign base_addr[16*g +: 16] = ba_q[g];
        assign curr_addr[16*g +: 16] = ca_q[g];
        assign base_cnt[16*g +: 16]  = bc_q[g];
        assign curr_cnt[16*g +: 16]  = cc_q[g];
    end

endmodule

// File: tb/tb_dma_reg_file.sv
// Directed bench for dma_reg_file (default build, temp register disabled).
module tb_dma_reg_file;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_n = 1'b1, ior_n = 1'b1, iow_n = 1'b1, hlda = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [7:0]  db_in = 8'h00;
    logic [7:0]  db_out;
    logic        db_oe;
    logic        upd_en = 1'b0;
    logic [1:0]  upd_ch = 2'd0;
    logic [15:0] upd_addr = 16'h0, upd_count = 16'h0;
    logic [3:0]  tc_set = 4'h0, dreq_stat = 4'h0;
    logic        temp_load = 1'b0;
    logic [7:0]  temp_in = 8'h00;
    logic [7:0]  cmd_reg;
    logic [31:0] mode_regs;
    logic [3:0]  mask_bits, req_bits;
    logic [63:0] base_addr, curr_addr, base_cnt, curr_cnt;

    int passed = 0;
    int total  = 0;

    dma_reg_file dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .ior_n(ior_n), .iow_n(iow_n), .hlda(hlda),
        .addr(addr), .db_in(db_in), .db_out(db_out), .db_oe(db_oe),
        .upd_en(upd_en), .upd_ch(upd_ch), .upd_addr(upd_addr), .upd_count(upd_count),
        .tc_set(tc_set), .dreq_stat(dreq_stat), .temp_load(temp_load), .temp_in(temp_in),
        .cmd_reg(cmd_reg), .mode_regs(mode_regs), .mask_bits(mask_bits), .req_bits(req_bits),
        .base_addr(base_addr), .curr_addr(curr_addr), .base_cnt(base_cnt), .curr_cnt(curr_cnt)
    );

    always #5 clk = ~clk;

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d, input logic upd);
        @(negedge clk); addr = a; db_in = d; cs_n = 1'b0; iow_n = 1'b0;
        @(negedge clk); iow_n = 1'b1; upd_en = upd;
        @(negedge clk); upd_en = 1'b0; cs_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [3:0] a, input logic [3:0] tcv,
                            output logic [7:0] d, output logic oe);
        @(negedge clk); addr = a; cs_n = 1'b0; ior_n = 1'b0;
        @(negedge clk); d = db_out; oe = db_oe; ior_n = 1'b1; tc_set = tcv;
        @(negedge clk); tc_set = 4'h0; cs_n = 1'b1;
    endtask

    task automatic pulse_tc(input logic [3:0] v);
        @(negedge clk); tc_set = v;
        @(negedge clk); tc_set = 4'h0;
    endtask

    task automatic test_reset;
        @(negedge clk); cs_n = 1'b0; ior_n = 1'b0; addr = 4'h8;
        #1;
        total++; if (db_oe !== 1'b0) $display("FAIL reset_db_oe: got %b expected 0", db_oe); else passed++;
        @(negedge clk); cs_n = 1'b1; ior_n = 1'b1; reset = 1'b0;
        @(negedge clk);
        total++; if (mask_bits !== 4'hF) $display("FAIL reset_mask: got %h expected f", mask_bits); else passed++;
        total++; if (cmd_reg !== 8'h00) $display("FAIL reset_cmd: got %h expected 00", cmd_reg); else passed++;
        total++; if ({base_addr, curr_addr, base_cnt, curr_cnt} !== 256'h0)
            $display("FAIL reset_addr_cnt: got nonzero expected 0"); else passed++;
    endtask

    task automatic test_chan_rw;
        logic [7:0] d; logic oe;
        cpu_write(4'hC, 8'h00, 1'b0);
        cpu_write(4'h2, 8'h34, 1'b0);
        cpu_write(4'h2, 8'h12, 1'b0);
        total++; if (base_addr[31:16] !== 16'h1234) $display("FAIL chan_base: got %h expected 1234", base_addr[31:16]); else passed++;
        total++; if (curr_addr[31:16] !== 16'h1234) $display("FAIL chan_curr: got %h expected 1234", curr_addr[31:16]); else passed++;
        cpu_read(4'h2, 4'h0, d, oe);
        total++; if ({oe, d} !== {1'b1, 8'h34}) $display("FAIL chan_read_lo: got %b/%h expected 1/34", oe, d); else passed++;
        cpu_read(4'h2, 4'h0, d, oe);
        total++; if (d !== 8'h12) $display("FAIL chan_read_hi: got %h expected 12", d); else passed++;
    endtask

    task automatic test_mode_mask;
        cpu_write(4'hB, 8'h56, 1'b0);
        total++; if (mode_regs[23:16] !== 8'h56) $display("FAIL mode_ch2: got %h expected 56", mode_regs[23:16]); else passed++;
        cpu_write(4'hE, 8'h00, 1'b0);
        cpu_write(4'hA, 8'h05, 1'b0);
        total++; if (mask_bits !== 4'b0010) $display("FAIL mask_single: got %b expected 0010", mask_bits); else passed++;
        cpu_write(4'hE, 8'h00, 1'b0);
        total++; if (mask_bits !== 4'b0000) $display("FAIL mask_clear: got %b expected 0000", mask_bits); else passed++;
        cpu_write(4'hF, 8'h09, 1'b0);
        total++; if (mask_bits !== 4'b1001) $display("FAIL mask_all: got %b expected 1001", mask_bits); else passed++;
        cpu_write(4'h9, 8'h06, 1'b0);
        total++; if (req_bits !== 4'b0100) $display("FAIL req_set: got %b expected 0100", req_bits); else passed++;
        cpu_write(4'h8, 8'h5A, 1'b0);
        total++; if (cmd_reg !== 8'h5A) $display("FAIL cmd_write: got %h expected 5a", cmd_reg); else passed++;
    endtask

    task automatic test_status;
        logic [7:0] d; logic oe;
        dreq_stat = 4'b0001;
        pulse_tc(4'b0100);
        total++; if (req_bits !== 4'b0000) $display("FAIL tc_req_clear: got %b expected 0000", req_bits); else passed++;
        total++; if (mask_bits !== 4'b1001) $display("FAIL tc_autoinit_mask: got %b expected 1001", mask_bits); else passed++;
        cpu_read(4'h8, 4'h0, d, oe);
        total++; if (d !== 8'h14) $display("FAIL status_first: got %h expected 14", d); else passed++;
        cpu_read(4'h8, 4'b1000, d, oe);
        total++; if (d !== 8'h10) $display("FAIL status_repeat: got %h expected 10", d); else passed++;
        cpu_read(4'h8, 4'h0, d, oe);
        total++; if (d !== 8'h18) $display("FAIL status_set_wins: got %h expected 18", d); else passed++;
        pulse_tc(4'b0010);
        total++; if (mask_bits !== 4'b1011) $display("FAIL tc_mask_set: got %b expected 1011", mask_bits); else passed++;
        total++; if (curr_addr[31:16] !== 16'h1234) $display("FAIL tc_no_reload: got %h expected 1234", curr_addr[31:16]); else passed++;
    endtask

    task automatic test_autoinit;
        cpu_write(4'hB, 8'h10, 1'b0);
        cpu_write(4'hE, 8'h00, 1'b0);
        cpu_write(4'hC, 8'h00, 1'b0);
        cpu_write(4'h1, 8'hFF, 1'b0);
        cpu_write(4'h1, 8'h00, 1'b0);
        total++; if (base_cnt[15:0] !== 16'h00FF) $display("FAIL ai_base_cnt: got %h expected 00ff", base_cnt[15:0]); else passed++;
        @(negedge clk); upd_ch = 2'd0; upd_addr = 16'h0; upd_count = 16'h0; upd_en = 1'b1;
        @(negedge clk); upd_en = 1'b0;
        total++; if (curr_cnt[15:0] !== 16'h0000) $display("FAIL ai_upd: got %h expected 0000", curr_cnt[15:0]); else passed++;
        pulse_tc(4'b0001);
        @(negedge clk);
        total++; if (curr_cnt[15:0] !== 16'h00FF) $display("FAIL ai_reload: got %h expected 00ff", curr_cnt[15:0]); else passed++;
        total++; if (mask_bits !== 4'b0000) $display("FAIL ai_mask: got %b expected 0000", mask_bits); else passed++;
    endtask

    task automatic test_upd_collision;
        upd_ch = 2'd3; upd_addr = 16'hABCD; upd_count = 16'h4321;
        cpu_write(4'h6, 8'h77, 1'b1);
        total++; if (curr_addr[63:48] !== 16'hAB77) $display("FAIL coll_curr: got %h expected ab77", curr_addr[63:48]); else passed++;
        total++; if (base_addr[63:48] !== 16'h0077) $display("FAIL coll_base: got %h expected 0077", base_addr[63:48]); else passed++;
        total++; if (curr_cnt[63:48] !== 16'h4321) $display("FAIL coll_cnt: got %h expected 4321", curr_cnt[63:48]); else passed++;
    endtask

    task automatic test_hlda;
        logic [7:0] d; logic oe;
        hlda = 1'b1;
        cpu_write(4'h8, 8'hAA, 1'b0);
        total++; if (cmd_reg !== 8'h5A) $display("FAIL hlda_cmd: got %h expected 5a", cmd_reg); else passed++;
        cpu_read(4'h8, 4'h0, d, oe);
        total++; if (oe !== 1'b0) $display("FAIL hlda_oe: got %b expected 0", oe); else passed++;
        hlda = 1'b0;
    endtask

    task automatic test_master_clear;
        logic [7:0] d; logic oe;
        cpu_write(4'hD, 8'h00, 1'b0);
        total++; if ({cmd_reg, mask_bits, req_bits, mode_regs} !== {8'h00, 4'hF, 4'h0, 32'h0})
            $display("FAIL mclr_regs: got %h/%h/%h/%h expected 00/f/0/0", cmd_reg, mask_bits, req_bits, mode_regs); else passed++;
        total++; if (curr_addr !== 64'h0) $display("FAIL mclr_curr: got %h expected 0", curr_addr); else passed++;
        cpu_write(4'h0, 8'h11, 1'b0);
        total++; if (base_addr[15:0] !== 16'h0011) $display("FAIL mclr_ptr: got %h expected 0011", base_addr[15:0]); else passed++;
        cpu_read(4'h8, 4'h0, d, oe);
        total++; if (d !== 8'h10) $display("FAIL mclr_tc: got %h expected 10", d); else passed++;
    endtask

    task automatic test_unlisted;
        logic [7:0] d; logic oe;
        cpu_read(4'hD, 4'h0, d, oe);
        total++; if ({oe, d} !== {1'b1, 8'h00}) $display("FAIL temp_read: got %b/%h expected 1/00", oe, d); else passed++;
        cpu_read(4'hA, 4'h0, d, oe);
        total++; if ({oe, d} !== {1'b1, 8'h00}) $display("FAIL unlisted_read: got %b/%h expected 1/00", oe, d); else passed++;
    endtask

    task automatic test_reset_abort;
        @(negedge clk); addr = 4'hF; db_in = 8'h00; cs_n = 1'b0; iow_n = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); iow_n = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); @(negedge clk); cs_n = 1'b1;
        total++; if (mask_bits !== 4'hF) $display("FAIL reset_abort: got %h expected f", mask_bits); else passed++;
    endtask

    initial begin
        test_reset;
        test_chan_rw;
        test_mode_mask;
        test_status;
        test_autoinit;
        test_upd_collision;
        test_hlda;
        test_master_clear;
        test_unlisted;
        test_reset_abort;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
